wishbone_reg_bank: RTL and testbench
====================================

Name: wishbone_reg_bank

Overview:
- Parametrised Wishbone slave holding NUM_REGS 32-bit control registers plus NUM_REGS 32-bit status inputs, at consecutive word addresses from BASE_ADDR.
- Sits on the Caravel user-area Wishbone bus (address space from 0x3000_0000) between the management SoC and user logic.
- Additions over the single-register slave:
  - multiple channels
  - byte-lane writes via wbs_sel_i
  - cyc qualification
  - single-cycle ack pulses
  - per-channel write/read strobes
  - defined reset of all outputs

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of register 0; must be 4-byte aligned and >= 32'h3000_0000.
- NUM_REGS, 4, number of register/status channels, legal range 1..64.
- RESET_VAL, 32'h0000_0000, reset value loaded into every control register.

Ports:
- wb_clk_i  input  1  bus clock; all state changes on rising edge.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- wbs_cyc_i  input  1  Wishbone cycle valid.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  1 = write, 0 = read.
- wbs_sel_i  input  4  byte-lane enables; bit n covers dat[8n+7:8n].
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- data_i  input  32*NUM_REGS  status words; channel k at [32k+31:32k].
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- reg_q_o  output  32*NUM_REGS  control registers; channel k at [32k+31:32k].
- wr_pulse_o  output  NUM_REGS  one-cycle strobe, bit k set when channel k is written.
- rd_pulse_o  output  NUM_REGS  one-cycle strobe, bit k set when channel k is read.

Behaviour:
- Reset (wb_rst_i high, asynchronous):
  - wbs_ack_o = 0, wbs_dat_o = 0, wr_pulse_o = 0, rd_pulse_o = 0.
  - Every reg_q_o channel = RESET_VAL.
- Hit decode (combinational):
  - hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[1:0] == 0) & (wbs_adr_i >= BASE_ADDR) & (wbs_adr_i < BASE_ADDR + 4*NUM_REGS).
  - idx = (wbs_adr_i - BASE_ADDR) >> 2.
  - Subtraction is 32-bit unsigned; the range compare is done before idx is used.
- Ack state machine, two states:
  - IDLE -> ACK when hit.
  - ACK -> IDLE unconditionally.
  - wbs_ack_o = 1 only in ACK, giving exactly one cycle of ack, one clock after the request is sampled.
  - While in ACK, hit is ignored, so a master holding stb high gets no double ack and no second side effect.
  - A master that keeps stb high after ack starts a new transfer: sampled in IDLE, acked two cycles after the previous ack.
- Write, on the IDLE->ACK edge with wbs_we_i = 1:
  - For each n with wbs_sel_i[n] = 1, reg_q_o[idx] byte n <= wbs_dat_i byte n; other bytes hold.
  - wr_pulse_o[idx] = 1 for that same cycle (coincident with wbs_ack_o), 0 otherwise.
  - wbs_sel_i = 0 still acks and pulses but changes no data.
- Read, on the IDLE->ACK edge with wbs_we_i = 0:
  - wbs_dat_o <= data_i[idx] (see Optional Feature); rd_pulse_o[idx] = 1 coincident with ack.
  - wbs_dat_o holds its last value at all other times; it is valid only while ack is high.
  - wbs_sel_i is ignored on reads.
- No ack is ever produced for:
  - misaligned addresses (adr[1:0] != 0)
  - out-of-range addresses, including adr == BASE_ADDR + 4*NUM_REGS
  - stb without cyc
  - cyc without stb
  Registers are unchanged and no pulse fires, so the bus interconnect times these out.
- Reset asserted mid-transfer (ACK state): ack drops immediately, state returns to IDLE and the pending write-pulse is cancelled. A write already latched at the edge is overwritten by RESET_VAL.
- reg_q_o changes only on acked writes. data_i is sampled only at the read-accept edge.

Optional Feature:
- Macro WB_REG_BANK_READBACK_EN.
- Defined: a read of channel k returns reg_q_o[k]; data_i is unused for reads; rd_pulse_o still fires.
- Undefined (default): a read of channel k returns data_i[k].
- Ack timing is identical in both builds.

Test Plan:
- Reset with RESET_VAL = 32'hA5A5_0000, NUM_REGS = 4 -> all reg_q_o = A5A5_0000; ack, dat_o and pulses = 0.
- Write 32'hDEAD_BEEF to 0x3000_0008, sel = 4'hF -> ack high exactly 1 cycle, one clock after request; reg_q_o[2] = DEAD_BEEF; wr_pulse_o = 4'b0100 for that cycle; other channels unchanged.
- Then write 32'h1122_3344 to 0x3000_0008 with sel = 4'b0101 -> reg_q_o[2] = DE22_BE44.
- data_i[3] = 32'h0000_CAFE, read 0x3000_000C -> dat_o = 0000_CAFE with ack; rd_pulse_o = 4'b1000. With WB_REG_BANK_READBACK_EN defined and reg_q_o[3] = 32'h0, dat_o = 0.
- Accesses to 0x3000_0010, 0x3000_0002, and 0x3000_0000 with cyc = 0 -> no ack within 8 cycles, no pulses, registers unchanged.
- stb and cyc held high for 6 cycles on a write -> acks in cycles 2 and 4 (and 6) relative to the first sampled request, never two consecutive; assert reset in an ACK cycle -> ack = 0 immediately, reg_q_o = RESET_VAL.

Source files
------------

// File: rtl/wishbone_reg_bank.sv
// Wishbone slave with NUM_REGS byte-writable control registers and NUM_REGS status read ports.
// Optional build macro WB_REG_BANK_READBACK_EN: reads return the control registers instead of data_i.
module wishbone_reg_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_REGS  = 4,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [32*NUM_REGS-1:0]  data_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [32*NUM_REGS-1:0]  reg_q_o,
  output logic [NUM_REGS-1:0]     wr_pulse_o,
  output logic [NUM_REGS-1:0]     rd_pulse_o
);

  localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One bit wider than the bus so a window ending at 2^32 cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                state_reg, state_next;
  logic                  hit, accept, wr_accept, rd_accept;
  logic [IDX_W-1:0]      idx;
  logic [NUM_REGS-1:0]   wr_sel, rd_sel;
  logic [NUM_REGS-1:0]   wr_pulse_reg, rd_pulse_reg;
  logic [31:0]           dat_reg;
  logic [31:0]           reg_q_reg [NUM_REGS];
  logic [31:0]           rd_src    [NUM_REGS];

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[1:0] == 2'b00) &
               (wbs_adr_i >= BASE_ADDR) & ({1'b0, wbs_adr_i} < END_ADDR);
  assign idx = IDX_W'((wbs_adr_i - BASE_ADDR) >> 2);

  // Requests are only taken in IDLE, so a held strobe cannot double-fire.
  assign accept    = (state_reg == S_IDLE) & hit;
  assign wr_accept = accept & wbs_we_i;
  assign rd_accept = accept & ~wbs_we_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (hit) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign wbs_ack_o = (state_reg == S_ACK);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_chan
      assign wr_sel[gi] = wr_accept & (idx == IDX_W'(gi));
      assign rd_sel[gi] = rd_accept & (idx == IDX_W'(gi));

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          reg_q_reg[gi] <= RESET_VAL;
        end else if (wr_sel[gi]) begin
          for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) reg_q_reg[gi][8*b +: 8] <= wbs_dat_i[8*b +: 8];
          end
        end
      end

      assign reg_q_o[32*gi +: 32] = reg_q_reg[gi];
`ifdef WB_REG_BANK_READBACK_EN
      assign rd_src[gi] = reg_q_reg[gi];
`else
      assign rd_src[gi] = data_i[32*gi +: 32];
`endif
    end
  endgenerate

`ifdef WB_REG_BANK_READBACK_EN
  logic unused_data;
  assign unused_data = ^data_i;
`endif

  // Pulses are registered on the accept edge so they line up with ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_pulse_reg <= '0;
      rd_pulse_reg <= '0;
      dat_reg      <= 32'h0;
    end else begin
      wr_pulse_reg <= wr_sel;
      rd_pulse_reg <= rd_sel;
      if (rd_accept) dat_reg <= rd_src[idx];
    end
  end

  assign wr_pulse_o = wr_pulse_reg;
  assign rd_pulse_o = rd_pulse_reg;
  assign wbs_dat_o  = dat_reg;

endmodule

// File: tb/tb_wishbone_reg_bank.sv
// Self-checking bench for wishbone_reg_bank: vector table, randomized accesses against a
// register-array model, and hand sequences for held strobe and reset during ack.
module tb_wishbone_reg_bank;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] RV   = 32'hA5A5_0000;

  logic            clk, rst;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic [32*N-1:0] data_in;
  logic            ack;
  logic [31:0]     dat_o;
  logic [32*N-1:0] reg_q;
  logic [N-1:0]    wr_pulse, rd_pulse;

  wishbone_reg_bank #(.BASE_ADDR(BASE), .NUM_REGS(N), .RESET_VAL(RV)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .data_i(data_in),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .reg_q_o(reg_q),
    .wr_pulse_o(wr_pulse), .rd_pulse_o(rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [31:0] m_reg [N];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [127:0] model_pack();
    logic [127:0] p;
    for (int k = 0; k < N; k++) p[32*k +: 32] = m_reg[k];
    return p;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Expected read value for channel k under the current build.
  function automatic logic [31:0] exp_read(input int k);
`ifdef WB_REG_BANK_READBACK_EN
    return m_reg[k];
`else
    return data_in[32*k +: 32];
`endif
  endfunction

  task automatic access(input logic a_we, input logic [31:0] a_adr, input logic [31:0] a_dat,
                        input logic [3:0] a_sel, input logic a_cyc, input logic a_stb,
                        output bit got_ack, output int lat, output logic [3:0] wr_seen,
                        output logic [3:0] rd_seen, output logic [31:0] rdat, output bit extra);
    @(negedge clk);
    we = a_we; adr = a_adr; wdat = a_dat; sel = a_sel; cyc = a_cyc; stb = a_stb;
    got_ack = 0; lat = -1; wr_seen = '0; rd_seen = '0; rdat = '0;
    for (int c = 0; c < 8 && !got_ack; c++) begin
      @(negedge clk);
      wr_seen |= wr_pulse;
      rd_seen |= rd_pulse;
      if (ack) begin got_ack = 1; lat = c; rdat = dat_o; end
    end
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    extra = ack | (|wr_pulse) | (|rd_pulse);
    $display("txn we=%0b adr=%h dat=%h sel=%h cyc=%0b stb=%0b ack=%0b lat=%0d wr=%b rd=%b rdat=%h",
             a_we, a_adr, a_dat, a_sel, a_cyc, a_stb, got_ack, lat, wr_seen, rd_seen, rdat);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        exp_ack;
    logic [3:0]  exp_wr;
    logic [3:0]  exp_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit got_ack, extra;
    int lat;
    logic [3:0] wr_seen, rd_seen;
    logic [31:0] rdat;
    logic [31:0] rd3, rd0;
    logic [3:0] ack_hist;

`ifdef WB_REG_BANK_READBACK_EN
    rd3 = RV; rd0 = RV;
`else
    rd3 = 32'h0000_CAFE; rd0 = 32'h1000_0000;
`endif
    vecs[0] = '{1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF,    1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 32'h0};
    vecs[1] = '{1'b1, 32'h3000_0008, 32'h1122_3344, 4'b0101, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 32'h0};
    vecs[2] = '{1'b0, 32'h3000_000C, 32'h0,         4'h0,    1'b1, 1'b1, 1'b1, 4'b0000, 4'b1000, rd3};
    vecs[3] = '{1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'hF,    1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0};
    vecs[4] = '{1'b1, 32'h3000_0002, 32'hFFFF_FFFF, 4'hF,    1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0};
    vecs[5] = '{1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF,    1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0};
    vecs[6] = '{1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF,    1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};
    vecs[7] = '{1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'h0,    1'b1, 1'b1, 1'b1, 4'b0010, 4'b0000, 32'h0};
    vecs[8] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF,    1'b1, 1'b1, 1'b1, 4'b0000, 4'b0001, rd0};
    vecs[9] = '{1'b1, 32'h2FFF_FFFC, 32'hFFFF_FFFF, 4'hF,    1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0};

    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    for (int k = 0; k < N; k++) data_in[32*k +: 32] = 32'h1000_0000 + k;
    data_in[32*3 +: 32] = 32'h0000_CAFE;
    for (int k = 0; k < N; k++) m_reg[k] = RV;

    repeat (3) @(negedge clk);
    chk("reset ack", 128'(ack), 128'(0));
    chk("reset dat_o", 128'(dat_o), 128'(0));
    chk("reset wr_pulse", 128'(wr_pulse), 128'(0));
    chk("reset rd_pulse", 128'(rd_pulse), 128'(0));
    chk("reset reg_q", reg_q, {4{RV}});
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].cyc, vecs[i].stb,
             got_ack, lat, wr_seen, rd_seen, rdat, extra);
      chk($sformatf("vec%0d ack", i), 128'(got_ack), 128'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) chk($sformatf("vec%0d latency", i), 128'(lat), 128'(0));
      chk($sformatf("vec%0d wr_pulse", i), 128'(wr_seen), 128'(vecs[i].exp_wr));
      chk($sformatf("vec%0d rd_pulse", i), 128'(rd_seen), 128'(vecs[i].exp_rd));
      if (vecs[i].exp_ack && !vecs[i].we) chk($sformatf("vec%0d rdata", i), 128'(rdat), 128'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d single ack", i), 128'(extra), 128'(0));
      if (vecs[i].exp_ack && vecs[i].we) begin
        int k;
        k = int'((vecs[i].adr - BASE) / 4);
        m_reg[k] = (m_reg[k] & ~lane_mask(vecs[i].sel)) | (vecs[i].dat & lane_mask(vecs[i].sel));
      end
      chk($sformatf("vec%0d reg_q", i), reg_q, model_pack());
      if (i == 1) chk("byte lane merge reg2", 128'(reg_q[95:64]), 128'(32'hDE22_BE44));
    end

    for (int i = 0; i < 60; i++) begin
      int r; bit mis, a_cyc, a_stb, a_we, exp_hit;
      logic [31:0] a_adr, a_dat; logic [3:0] a_sel;
      r = int'($urandom_range(0, 6));
      mis = ($urandom_range(0, 7) == 0);
      a_cyc = ($urandom_range(0, 7) != 0);
      a_stb = ($urandom_range(0, 7) != 0);
      a_we = $urandom_range(0, 1) == 1;
      a_dat = $urandom;
      a_sel = 4'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) data_in[32*k +: 32] = $urandom;
      a_adr = (r == 6) ? BASE - 32'd4 : BASE + 32'(4 * r);
      if (mis) a_adr = a_adr + 32'($urandom_range(1, 3));
      exp_hit = a_cyc && a_stb && !mis && (r < N);
      access(a_we, a_adr, a_dat, a_sel, a_cyc, a_stb, got_ack, lat, wr_seen, rd_seen, rdat, extra);
      chk($sformatf("rnd%0d ack", i), 128'(got_ack), 128'(exp_hit));
      chk($sformatf("rnd%0d wr_pulse", i), 128'(wr_seen), 128'((exp_hit && a_we) ? (4'b1 << r) : 4'b0));
      chk($sformatf("rnd%0d rd_pulse", i), 128'(rd_seen), 128'((exp_hit && !a_we) ? (4'b1 << r) : 4'b0));
      if (exp_hit && !a_we) chk($sformatf("rnd%0d rdata", i), 128'(rdat), 128'(exp_read(r)));
      if (exp_hit && a_we) m_reg[r] = (m_reg[r] & ~lane_mask(a_sel)) | (a_dat & lane_mask(a_sel));
      chk($sformatf("rnd%0d reg_q", i), reg_q, model_pack());
    end

    // Strobe held for six cycles: every other cycle acks.
    @(negedge clk);
    we = 1; adr = BASE + 32'd4; wdat = 32'h0BAD_F00D; sel = 4'hF; cyc = 1; stb = 1;
    ack_hist = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("hold ack c%0d", k), 128'(ack), 128'((k % 2) == 1));
      chk($sformatf("hold wr_pulse c%0d", k), 128'(wr_pulse), 128'(((k % 2) == 1) ? 4'b0010 : 4'b0000));
      ack_hist = {ack_hist[2:0], ack};
      if (ack_hist[1:0] == 2'b11) chk("hold no back-to-back ack", 128'(1), 128'(0));
    end
    cyc = 0; stb = 0; we = 0;
    $display("txn held-strobe write adr=%h dat=%h", BASE + 32'd4, 32'h0BAD_F00D);
    m_reg[1] = 32'h0BAD_F00D;
    @(negedge clk);
    chk("hold reg_q", reg_q, model_pack());

    // Reset arriving during the ack cycle.
    we = 1; adr = BASE; wdat = 32'hFFFF_FFFF; sel = 4'hF; cyc = 1; stb = 1;
    @(negedge clk);
    chk("rst-in-ack ack before", 128'(ack), 128'(1));
    rst = 1;
    #1;
    chk("rst-in-ack ack", 128'(ack), 128'(0));
    chk("rst-in-ack wr_pulse", 128'(wr_pulse), 128'(0));
    chk("rst-in-ack reg_q", reg_q, {4{RV}});
    chk("rst-in-ack dat_o", 128'(dat_o), 128'(0));
    $display("txn reset during ack adr=%h", BASE);
    cyc = 0; stb = 0; we = 0;
    for (int k = 0; k < N; k++) m_reg[k] = RV;
    @(negedge clk);
    rst = 0;

    data_in[32*2 +: 32] = 32'h5555_AAAA;
    access(1'b0, BASE + 32'd8, 32'h0, 4'h0, 1'b1, 1'b1, got_ack, lat, wr_seen, rd_seen, rdat, extra);
    chk("post-reset read ack", 128'(got_ack), 128'(1));
    chk("post-reset read rdata", 128'(rdat), 128'(exp_read(2)));
    chk("post-reset rd_pulse", 128'(rd_seen), 128'(4'b0100));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
